// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised raster timing generator. Two chained counters
//                (pixel / line) advance on pix_en and drive registered sync,
//                blanking, visible coordinates, line/frame strobes and a
//                frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               blank_n,
    output logic               sync_n,
    output logic [CW-1:0]      posx,
    output logic [CW-1:0]      posy,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] C_H_LAST     = CW'(C_H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST     = CW'(C_V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] C_HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] C_VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] C_VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Reject degenerate geometry and counters too narrow for the totals.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CW < 1 || FRAME_W < 1) begin : g_bad_param
        $error("vga_timing_gen: every geometry/width parameter must be >= 1");
    end
    if (((C_H_TOTAL - 1) >> CW) != 0 || ((C_V_TOTAL - 1) >> CW) != 0) begin : g_bad_width
        $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic [CW-1:0] w_hcount_nxt;
    logic [CW-1:0] w_vcount_nxt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_h_sync_nxt;
    logic          w_v_sync_nxt;

    // Next-state counters: pixel counter ticks on pix_en, line counter on pixel wrap.
    always_comb begin
        w_h_wrap     = pix_en && (r_hcount == C_H_LAST);
        w_v_wrap     = w_h_wrap && (r_vcount == C_V_LAST);
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (pix_en) begin
            w_hcount_nxt = w_h_wrap ? '0 : r_hcount + CW'(1);
        end
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? '0 : r_vcount + CW'(1);
        end
    end

    // Decode from next-state counters so registered outputs line up with the counters.
    always_comb begin
        w_h_act      = (w_hcount_nxt < C_H_ACT);
        w_v_act      = (w_vcount_nxt < C_V_ACT);
        w_h_sync_nxt = (w_hcount_nxt >= C_HS_START && w_hcount_nxt < C_HS_END) ? H_POL : ~H_POL;
        w_v_sync_nxt = (w_vcount_nxt >= C_VS_START && w_vcount_nxt < C_VS_END) ? V_POL : ~V_POL;
    end

    // Counter, decoded-output and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount    <= '0;
            r_vcount    <= '0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            blank_n     <= 1'b1;
            posx        <= '0;
            posy        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            r_hcount    <= w_hcount_nxt;
            r_vcount    <= w_vcount_nxt;
            h_sync      <= w_h_sync_nxt;
            v_sync      <= w_v_sync_nxt;
            blank_n     <= w_h_act && w_v_act;
            posx        <= w_h_act ? w_hcount_nxt : '0;
            posy        <= w_v_act ? w_vcount_nxt : '0;
            line_start  <= w_h_wrap;
            frame_start <= w_v_wrap;
            if (w_v_wrap) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

    // Composite sync is not used by this raster; hold the DAC input inactive.
    assign sync_n = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed self-checking bench for vga_timing_gen: a default
//                640x480 instance and a small override instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default-geometry instance
    logic       rst_a = 1'b1;
    logic       pen_a = 1'b0;
    logic       hs_a, vs_a, bl_a, sn_a, ls_a, fs_a;
    logic [9:0] px_a, py_a;
    logic [7:0] fc_a;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .pix_en      (pen_a),
        .h_sync      (hs_a),
        .v_sync      (vs_a),
        .blank_n     (bl_a),
        .sync_n      (sn_a),
        .posx        (px_a),
        .posy        (py_a),
        .line_start  (ls_a),
        .frame_start (fs_a),
        .frame_count (fc_a)
    );

    // Small override instance: H_TOTAL=12, V_TOTAL=7, positive syncs
    logic       rst_b = 1'b1;
    logic       pen_b = 1'b1;
    logic       hs_b, vs_b, bl_b, sn_b, ls_b, fs_b;
    logic [9:0] px_b, py_b;
    logic [1:0] fc_b;

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL (1'b1), .V_POL (1'b1), .FRAME_W (2)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .pix_en      (pen_b),
        .h_sync      (hs_b),
        .v_sync      (vs_b),
        .blank_n     (bl_b),
        .sync_n      (sn_b),
        .posx        (px_b),
        .posy        (py_b),
        .line_start  (ls_b),
        .frame_start (fs_b),
        .frame_count (fc_b)
    );

    // Asynchronous reset values on both instances, no clock edge needed.
    task automatic test_reset();
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        n_tests++;
        if ({hs_a, vs_a, bl_a, sn_a, ls_a, fs_a} !== 6'b111100) begin
            n_fail++; $display("FAIL reset_flags_a: got %b want 111100", {hs_a, vs_a, bl_a, sn_a, ls_a, fs_a});
        end
        n_tests++;
        if (px_a !== 10'd0 || py_a !== 10'd0 || fc_a !== 8'd0) begin
            n_fail++; $display("FAIL reset_pos_a: got posx=%0d posy=%0d fc=%0d want 0 0 0", px_a, py_a, fc_a);
        end
        n_tests++;
        if ({hs_b, vs_b, bl_b, sn_b, ls_b, fs_b} !== 6'b001100) begin
            n_fail++; $display("FAIL reset_flags_b: got %b want 001100", {hs_b, vs_b, bl_b, sn_b, ls_b, fs_b});
        end
        n_tests++;
        if (px_b !== 10'd0 || py_b !== 10'd0 || fc_b !== 2'd0) begin
            n_fail++; $display("FAIL reset_pos_b: got posx=%0d posy=%0d fc=%0d want 0 0 0", px_b, py_b, fc_b);
        end
    endtask

    // Continuous pix_en: hsync 656..751, blanking/position, line period 800.
    task automatic test_line_timing();
        int h = 0;
        int v = 0;
        bit ls;
        int last = -1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        pen_a = 1'b1;
        for (int cyc = 1; cyc <= 1700; cyc++) begin
            @(posedge clk);
            ls = (h == 799);
            h  = ls ? 0 : h + 1;
            if (ls) v = v + 1;
            @(negedge clk);
            n_tests++;
            if (hs_a !== !(h >= 656 && h < 752)) begin
                n_fail++; $display("FAIL h_sync h=%0d: got %b want %b", h, hs_a, !(h >= 656 && h < 752));
            end
            n_tests++;
            if (vs_a !== 1'b1 || fs_a !== 1'b0 || fc_a !== 8'd0) begin
                n_fail++; $display("FAIL vframe h=%0d: got vs=%b fs=%b fc=%0d want 1 0 0", h, vs_a, fs_a, fc_a);
            end
            n_tests++;
            if (bl_a !== (h < 640) || px_a !== 10'((h < 640) ? h : 0) || py_a !== 10'(v)) begin
                n_fail++; $display("FAIL blank_pos h=%0d v=%0d: got bl=%b x=%0d y=%0d", h, v, bl_a, px_a, py_a);
            end
            n_tests++;
            if (ls_a !== ls) begin
                n_fail++; $display("FAIL line_start cyc=%0d: got %b want %b", cyc, ls_a, ls);
            end
            if (ls_a === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last != 800) begin
                        n_fail++; $display("FAIL line_period: got %0d want 800", cyc - last);
                    end
                end
                last = cyc;
            end
        end
    endtask

    // pix_en 1-in-2: everything scales, outputs hold on idle clocks, pulses 1 clk.
    task automatic test_pix_en_alt();
        int h = 0;
        int v = 0;
        bit ls;
        int last = -1;
        logic [9:0] prev_x = 10'd0;
        logic       prev_hs = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        for (int cyc = 1; cyc <= 3400; cyc++) begin
            pen_a = (cyc % 2 == 1);
            @(posedge clk);
            ls = 1'b0;
            if (pen_a) begin
                ls = (h == 799);
                h  = ls ? 0 : h + 1;
                if (ls) v = v + 1;
            end
            @(negedge clk);
            n_tests++;
            if (hs_a !== !(h >= 656 && h < 752) || px_a !== 10'((h < 640) ? h : 0) || py_a !== 10'(v)) begin
                n_fail++; $display("FAIL alt_levels cyc=%0d h=%0d: got hs=%b x=%0d y=%0d", cyc, h, hs_a, px_a, py_a);
            end
            n_tests++;
            if (ls_a !== ls) begin
                n_fail++; $display("FAIL alt_line_start cyc=%0d: got %b want %b", cyc, ls_a, ls);
            end
            if (!pen_a) begin
                n_tests++;
                if (px_a !== prev_x || hs_a !== prev_hs) begin
                    n_fail++; $display("FAIL alt_hold cyc=%0d: got x=%0d hs=%b want x=%0d hs=%b", cyc, px_a, hs_a, prev_x, prev_hs);
                end
            end
            prev_x  = px_a;
            prev_hs = hs_a;
            if (ls_a === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last != 1600) begin
                        n_fail++; $display("FAIL alt_line_period: got %0d want 1600", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        pen_a = 1'b1;
    endtask

    // Reset asserted mid-line at hcount=300, vcount=2, then resume from origin.
    task automatic test_mid_reset();
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        pen_a = 1'b1;
        repeat (1900) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (px_a !== 10'd300 || py_a !== 10'd2) begin
            n_fail++; $display("FAIL pre_reset_pos: got x=%0d y=%0d want 300 2", px_a, py_a);
        end
        rst_a = 1'b0;
        #1;
        n_tests++;
        if ({hs_a, vs_a, bl_a, ls_a, fs_a} !== 5'b11100 || px_a !== 10'd0 || py_a !== 10'd0 || fc_a !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset: got flags=%b x=%0d y=%0d fc=%0d want 11100 0 0 0",
                               {hs_a, vs_a, bl_a, ls_a, fs_a}, px_a, py_a, fc_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        n_tests++;
        if (px_a !== 10'd1 || py_a !== 10'd0 || ls_a !== 1'b0) begin
            n_fail++; $display("FAIL resume: got x=%0d y=%0d ls=%b want 1 0 0", px_a, py_a, ls_a);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (px_a !== 10'd3) begin
            n_fail++; $display("FAIL resume_count: got x=%0d want 3", px_a);
        end
    endtask

    // Override geometry: positive syncs, 84-clk frame, 2-bit frame counter wrap.
    task automatic test_override();
        int h = 0;
        int v = 0;
        bit ls;
        bit fs;
        int fc = 0;
        int last = -1;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        pen_b = 1'b1;
        for (int cyc = 1; cyc <= 346; cyc++) begin
            @(posedge clk);
            ls = (h == 11);
            fs = ls && (v == 6);
            h  = ls ? 0 : h + 1;
            if (fs) begin
                v  = 0;
                fc = (fc + 1) % 4;
            end else if (ls) begin
                v = v + 1;
            end
            @(negedge clk);
            n_tests++;
            if (hs_b !== (h >= 9 && h < 11) || vs_b !== (v == 5)) begin
                n_fail++; $display("FAIL ovr_sync h=%0d v=%0d: got hs=%b vs=%b", h, v, hs_b, vs_b);
            end
            n_tests++;
            if (bl_b !== (h < 8 && v < 4) || px_b !== 10'((h < 8) ? h : 0) || py_b !== 10'((v < 4) ? v : 0)) begin
                n_fail++; $display("FAIL ovr_pos h=%0d v=%0d: got bl=%b x=%0d y=%0d", h, v, bl_b, px_b, py_b);
            end
            n_tests++;
            if (ls_b !== ls || fs_b !== fs || fc_b !== 2'(fc)) begin
                n_fail++; $display("FAIL ovr_strobe cyc=%0d: got ls=%b fs=%b fc=%0d want %b %b %0d",
                                   cyc, ls_b, fs_b, fc_b, ls, fs, fc);
            end
            if (fs_b === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last != 84) begin
                        n_fail++; $display("FAIL ovr_frame_period: got %0d want 84", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_tests++;
        if (fc_b !== 2'd0) begin
            n_fail++; $display("FAIL ovr_fc_wrap: got %0d want 0", fc_b);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        rst_b = 1'b1;
        test_line_timing();
        test_pix_en_alt();
        test_mid_reset();
        test_override();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
